// File: rtl/prpg_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : prpg_pattern_gen
// Purpose  : BIST stimulus source. A Fibonacci LFSR issues a programmable
//            number of pseudo-random patterns, starting from a loadable
//            seed, over a valid/ready handshake. It reports busy while a
//            run is in progress and pulses done for one cycle when the run
//            completes.
// Options  : PRPG_DEBRUIJN_EN - when defined, the all-zero state is spliced
//            into the sequence (period 2^WIDTH) and seed 0 is stored as-is.
//            When undefined, the generator is a plain maximal LFSR
//            (period 2^WIDTH-1) and a zero seed is replaced by 1.
// Ports    : clk       - clock, all logic on the rising edge
//            rst       - synchronous active-high reset
//            seed_load - write seed into the seed register (IDLE only)
//            seed      - seed value
//            start     - begin a run (IDLE only)
//            n_pat     - pattern count for the run, sampled on accepted start
//            pat       - current pattern (the LFSR register)
//            pat_valid - pat is valid for the consumer
//            pat_ready - consumer accepts pat this cycle
//            pat_idx   - 0-based index of the current pattern within the run
//            busy      - run in progress
//            done      - one-cycle pulse at run completion
// Revision : 1.0 - initial release
// ============================================================================
module prpg_pattern_gen #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = 5'b10100,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             start,
  input  logic [CNT_W-1:0] n_pat,
  output logic [WIDTH-1:0] pat,
  output logic             pat_valid,
  input  logic             pat_ready,
  output logic [CNT_W-1:0] pat_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] seed_reg;
  logic [CNT_W-1:0] n_lat;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] seed_in;
  logic             fb;
  logic             accept;
  logic             last;

  always_comb begin
    fb = ^(lfsr & TAPS);
`ifdef PRPG_DEBRUIJN_EN
    // Flipping the feedback when the low bits are all zero inserts the
    // all-zero state between 10..0 and 0..01, giving a full 2^WIDTH cycle.
    fb = fb ^ (lfsr[WIDTH-2:0] == '0);
`endif
    lfsr_next = {lfsr[WIDTH-2:0], fb};
  end

`ifdef PRPG_DEBRUIJN_EN
  assign seed_in = seed;
`else
  // All-zero is the lock-up state of a plain LFSR, so never store it.
  assign seed_in = (seed == '0) ? ONE_W : seed;
`endif

  assign accept = pat_valid & pat_ready;
  assign last   = (pat_idx == n_lat - CNT_W'(1));
  assign pat    = lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lfsr      <= ONE_W;
      seed_reg  <= ONE_W;
      n_lat     <= '0;
      pat_idx   <= '0;
      pat_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A start in the same cycle as seed_load launches from the old
          // seed; the new seed only takes effect for the following run.
          if (seed_load) begin
            seed_reg <= seed_in;
          end
          if (start) begin
            lfsr    <= seed_reg;
            pat_idx <= '0;
            n_lat   <= n_pat;
            if (n_pat != '0) begin
              state     <= S_RUN;
              busy      <= 1'b1;
              pat_valid <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (accept) begin
            lfsr    <= lfsr_next;
            pat_idx <= pat_idx + CNT_W'(1);
            if (last) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              pat_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          pat_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prpg_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_prpg_pattern_gen
// Purpose  : Self-checking bench for prpg_pattern_gen with default
//            parameters. Expected patterns come from an arithmetic reference
//            of the LFSR recurrence plus a model of the seed register.
//            Honours PRPG_DEBRUIJN_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prpg_pattern_gen;

  localparam int WIDTH = 5;
  localparam int CNT_W = 8;
  localparam int TAPS_I = 20;    // 5'b10100
  localparam int MODW = 32;      // 2^WIDTH
  localparam int BUDGET = 2000;

  logic             clk = 1'b0;
  logic             rst;
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             start;
  logic [CNT_W-1:0] n_pat;
  logic [WIDTH-1:0] pat;
  logic             pat_valid;
  logic             pat_ready;
  logic [CNT_W-1:0] pat_idx;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;
  int m_seed;                     // model of the seed register
  int tbl [6] = '{1, 2, 4, 9, 18, 5};

  prpg_pattern_gen dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .start     (start),
    .n_pat     (n_pat),
    .pat       (pat),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .pat_idx   (pat_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Successor of x: shift left within WIDTH bits, feedback = parity of the
  // tapped bits (optionally toggled when the low WIDTH-1 bits are zero).
  function automatic int nxt(input int x);
    int ones = 0;
    int fb;
    for (int i = 0; i < WIDTH; i++)
      if (((TAPS_I >> i) % 2 == 1) && ((x >> i) % 2 == 1)) ones++;
    fb = ones % 2;
`ifdef PRPG_DEBRUIJN_EN
    if (x % (MODW / 2) == 0) fb = 1 - fb;
`endif
    return ((x * 2) % MODW) + fb;
  endfunction

  function automatic int seedfix(input int v);
`ifdef PRPG_DEBRUIJN_EN
    return v;
`else
    return (v == 0) ? 1 : v;
`endif
  endfunction

  // One run: start (optionally with seed_load) then drive random
  // back-pressure and ignored start/seed_load noise until done.
  task automatic run(input bit ld, input int sv, input int np,
                     input int rdy_pct, input bit use_tbl);
    int cur;
    int idx;
    int cyc;
    bit r;
    @(negedge clk);
    seed_load = ld;
    seed      = sv[WIDTH-1:0];
    start     = 1'b1;
    n_pat     = np[CNT_W-1:0];
    cur = m_seed;
    if (ld) m_seed = seedfix(sv % MODW);
    @(negedge clk);
    start     = 1'b0;
    seed_load = 1'b0;
    if (np == 0) begin
      chk("zero_done", done, 1);
      chk("zero_valid", pat_valid, 0);
      chk("zero_busy", busy, 0);
      @(negedge clk);
      chk("zero_done_clr", done, 0);
      chk("zero_valid2", pat_valid, 0);
      return;
    end
    idx = 0;
    cyc = 0;
    forever begin
      chk("valid", pat_valid, 1);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("pat", pat, (use_tbl && idx < 6) ? tbl[idx] : cur);
      chk("idx", pat_idx, idx);
      r = ($urandom_range(99) < rdy_pct);
      pat_ready = r;
      start     = 1'($urandom_range(1));
      seed_load = 1'($urandom_range(1));
      seed      = WIDTH'($urandom);
      n_pat     = CNT_W'($urandom);
      @(negedge clk);
      cyc++;
      if (r) begin
        idx++;
        cur = nxt(cur);
        if (idx == np) break;
      end
      if (cyc > BUDGET) begin
        chk("timeout", 1, 0);
        start = 1'b0;
        seed_load = 1'b0;
        return;
      end
    end
    start     = 1'b0;
    seed_load = 1'b0;
    pat_ready = 1'b0;
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("valid_end", pat_valid, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; seed_load = 1'b0; seed = '0; start = 1'b0;
    n_pat = '0; pat_ready = 1'b0;
    m_seed = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_pat", pat, 1);
    chk("rst_valid", pat_valid, 0);
    chk("rst_idx", pat_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // Known sequence from seed 01, full throughput then with stalls.
    run(1'b1, 1, 6, 100, 1'b1);
    run(1'b0, 0, 6, 50, 1'b1);
    // Zero-length run.
    run(1'b0, 0, 0, 100, 1'b0);
    // Zero seed then a run longer than the period.
    run(1'b1, 0, 32, 100, 1'b0);
    run(1'b0, 0, 40, 60, 1'b0);
    // New seed with start in the same cycle, then a run from the new seed.
    run(1'b1, 31, 4, 100, 1'b0);
    run(1'b0, 0, 3, 100, 1'b0);

    // Reset in the middle of a run.
    @(negedge clk);
    start = 1'b1; n_pat = 8'd10; pat_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (pat_idx != 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_idx", pat_idx, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pat_ready = 1'b0;
    m_seed = 1;
    chk("mid_pat", pat, 1);
    chk("mid_valid", pat_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    @(negedge clk);
    chk("mid_done2", done, 0);

    // Randomized runs.
    for (int k = 0; k < 25; k++)
      run(1'($urandom_range(1)), int'($urandom_range(MODW - 1)),
          int'($urandom_range(40)), int'($urandom_range(30, 100)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
